fcmp_sequencer: RTL and testbench

- Sequences the shared floating-point magnitude comparator for the F-extension compare class: FEQ.S, FLT.S, FLE.S, FMIN.S, FMAX.S.
- Sits between the FPU issue stage and the comparator instance, and exposes valid/ready handshakes on both sides.
- The comparator ignores sign and NaNs. This block adds sign resolution, NaN/sNaN handling, ±0 ordering and NV flag generation, then returns a 32-bit result with the destination tag.

---
 rtl/fcmp_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fcmp_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fcmp_sequencer.sv
// Compare-class sequencer (FEQ/FLT/FLE/FMIN/FMAX) around a shared magnitude comparator.
// Define FCMP_CLASS_EN to enable FCLASS.S on op 101; otherwise op 101 is reserved.
module fcmp_sequencer #(
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic [1:0]       cmp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nv
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_op;
  logic [31:0]      r_a, r_b, r_data;
  logic [TAG_W-1:0] r_tag;
  logic             r_nv;

  logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_any_nan, w_any_snan;
  logic        w_both_zero, w_eq, w_lt, w_gt;
  logic [31:0] w_min, w_max, w_result;
  logic        w_nv;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // flush outranks both a new request and a pending result
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!flush && in_valid) w_state_next = S_EVAL;
      S_EVAL:  w_state_next = flush ? S_IDLE : S_DONE;
      S_DONE:  if (flush || out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op   <= 3'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_tag  <= '0;
      r_data <= 32'd0;
      r_nv   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_state_next == S_EVAL) begin
        r_op  <= in_op;
        r_a   <= in_a;
        r_b   <= in_b;
        r_tag <= in_tag;
      end
      if (r_state == S_EVAL) begin
        r_data <= w_result;
        r_nv   <= w_nv;
      end
    end
  end

  assign cmp_a    = r_a;
  assign cmp_b    = r_b;
  assign out_data = r_data;
  assign out_tag  = r_tag;
  assign out_nv   = r_nv;

  assign w_a_nan     = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan     = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_snan    = w_a_nan && !r_a[22];
  assign w_b_snan    = w_b_nan && !r_b[22];
  assign w_any_nan   = w_a_nan || w_b_nan;
  assign w_any_snan  = w_a_snan || w_b_snan;
  assign w_both_zero = (r_a[30:0] == 31'd0) && (r_b[30:0] == 31'd0);

  // Signed ordering from the magnitude result; negatives swap the sense of A>B/A<B
  always_comb begin
    w_eq = 1'b0;
    w_lt = 1'b0;
    w_gt = 1'b0;
    if (w_both_zero) begin
      w_eq = 1'b1;
    end else if (r_a[31] != r_b[31]) begin
      w_gt = !r_a[31];
      w_lt = r_a[31];
    end else begin
      w_eq = (cmp_result == 2'b00);
      w_gt = r_a[31] ? (cmp_result == 2'b10) : (cmp_result == 2'b01);
      w_lt = r_a[31] ? (cmp_result == 2'b01) : (cmp_result == 2'b10);
    end
  end

  always_comb begin
    w_min = 32'h7FC00000;
    w_max = 32'h7FC00000;
    if (w_a_nan && w_b_nan) begin
      w_min = 32'h7FC00000;
      w_max = 32'h7FC00000;
    end else if (w_a_nan) begin
      w_min = r_b;
      w_max = r_b;
    end else if (w_b_nan) begin
      w_min = r_a;
      w_max = r_a;
    end else if (w_both_zero) begin
      w_min = r_a[31] ? r_a : r_b;
      w_max = r_a[31] ? r_b : r_a;
    end else begin
      w_min = w_gt ? r_b : r_a;
      w_max = w_lt ? r_b : r_a;
    end
  end

`ifdef FCMP_CLASS_EN
  logic [9:0] w_class;
  logic       w_exp_max, w_exp_zero, w_man_zero;

  assign w_exp_max  = (r_a[30:23] == 8'hFF);
  assign w_exp_zero = (r_a[30:23] == 8'h00);
  assign w_man_zero = (r_a[22:0] == 23'd0);

  always_comb begin
    w_class = 10'd0;
    if (w_exp_max && !w_man_zero)     w_class[r_a[22] ? 9 : 8] = 1'b1;
    else if (w_exp_max)               w_class[r_a[31] ? 0 : 7] = 1'b1;
    else if (w_exp_zero && w_man_zero) w_class[r_a[31] ? 3 : 4] = 1'b1;
    else if (w_exp_zero)              w_class[r_a[31] ? 2 : 5] = 1'b1;
    else                              w_class[r_a[31] ? 1 : 6] = 1'b1;
  end
`endif

  always_comb begin
    w_result = 32'd0;
    w_nv     = 1'b0;
    case (r_op)
      3'b000: begin
        w_result = {31'd0, w_eq && !w_any_nan};
        w_nv     = w_any_snan;
      end
      3'b001: begin
        w_result = {31'd0, w_lt && !w_any_nan};
        w_nv     = w_any_nan;
      end
      3'b010: begin
        w_result = {31'd0, (w_lt || w_eq) && !w_any_nan};
        w_nv     = w_any_nan;
      end
      3'b011: begin
        w_result = w_min;
        w_nv     = w_any_snan;
      end
      3'b100: begin
        w_result = w_max;
        w_nv     = w_any_snan;
      end
`ifdef FCMP_CLASS_EN
      3'b101: w_result = {22'd0, w_class};
`endif
      default: begin
        w_result = 32'd0;
        w_nv     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fcmp_sequencer.sv
// Directed self-checking bench for fcmp_sequencer; a behavioural magnitude comparator
// stands in for the shared comparator instance.
module tb_fcmp_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic [31:0] cmp_a, cmp_b;
  logic [1:0]  cmp_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_nv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign cmp_result = (cmp_a[30:0] == cmp_b[30:0]) ? 2'b00 :
                      (cmp_a[30:0] >  cmp_b[30:0]) ? 2'b01 : 2'b10;

  fcmp_sequencer #(.TAG_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_result(cmp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_nv(out_nv)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request, wait (bounded) for the result, then take it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] data, output logic nv,
                        output logic [4:0] otag, output int lat);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    data = out_data; nv = out_nv; otag = out_tag;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic op_check(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input logic exp_nv);
    logic [31:0] d;
    logic        nv;
    logic [4:0]  t;
    int          lat;
    run_op(op, a, b, 5'd3, d, nv, t, lat);
    check({name, ".data"}, d, exp_data);
    check({name, ".nv"}, {31'd0, nv}, {31'd0, exp_nv});
  endtask

  initial begin
    logic [31:0] d;
    logic        nv;
    logic [4:0]  t;
    int          lat;

    RESET = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 32'd0; in_b = 32'd0;
    in_tag = 5'd0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_data", out_data, 32'd0);
    check("rst.out_tag", {27'd0, out_tag}, 32'd0);
    check("rst.out_nv", {31'd0, out_nv}, 32'd0);
    check("rst.cmp_a", cmp_a, 32'd0);
    check("rst.cmp_b", cmp_b, 32'd0);
    RESET = 1'b0;
    tick();

    run_op(3'b001, 32'hC0000000, 32'hBF800000, 5'd21, d, nv, t, lat);
    check("flt_neg.data", d, 32'd1);
    check("flt_neg.nv", {31'd0, nv}, 32'd0);
    check("flt_neg.latency", lat, 32'd2);
    check("flt_neg.tag", {27'd0, t}, 32'd21);

    op_check("fmin_zero", 3'b011, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    op_check("fmax_zero", 3'b100, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    op_check("feq_zero", 3'b000, 32'h00000000, 32'h80000000, 32'd1, 1'b0);
    op_check("feq_qnan", 3'b000, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b0);
    op_check("fle_qnan", 3'b010, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b1);
    op_check("fmax_snan", 3'b100, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1);
    op_check("fmin_2nan", 3'b011, 32'h7FC00000, 32'h7FC00001, 32'h7FC00000, 1'b0);
    op_check("fmax_mixed", 3'b100, 32'h3F800000, 32'hC0000000, 32'h3F800000, 1'b0);
    op_check("fmin_neg", 3'b011, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0);
    op_check("fle_eq", 3'b010, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0);
    op_check("flt_pos_gt", 3'b001, 32'h40000000, 32'h3F800000, 32'd0, 1'b0);
    op_check("rsvd_110", 3'b110, 32'h3F800000, 32'h40000000, 32'd0, 1'b0);
`ifdef FCMP_CLASS_EN
    op_check("fclass_ninf", 3'b101, 32'hFF800000, 32'h0, 32'h001, 1'b0);
    op_check("fclass_snan", 3'b101, 32'h7F800001, 32'h0, 32'h100, 1'b0);
`else
    op_check("op101_rsvd", 3'b101, 32'hFF800000, 32'h0, 32'h0, 1'b0);
`endif

    // Backpressure: result must hold while out_ready is low
    in_valid = 1'b1; in_op = 3'b010; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp.valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp.data%0d", i), out_data, 32'd1);
      check($sformatf("bp.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release_valid", {31'd0, out_valid}, 32'd0);
    check("bp.release_in_ready", {31'd0, in_ready}, 32'd1);

    // flush while in EVAL
    in_valid = 1'b1; in_op = 3'b001; in_a = 32'h3F800000; in_b = 32'h40000000;
    tick();
    in_valid = 1'b0;
    check("fl_eval.in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_eval.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_eval.in_ready_after", {31'd0, in_ready}, 32'd1);
    op_check("fl_eval.next", 3'b001, 32'h3F800000, 32'h40000000, 32'd1, 1'b0);

    // RESET while in DONE
    in_valid = 1'b1; in_op = 3'b100; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'd7;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_done.valid_before", {31'd0, out_valid}, 32'd1);
    check("rst_done.data_before", out_data, 32'h40000000);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst_done.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done.out_data", out_data, 32'd0);
    check("rst_done.out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_done.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_done.cmp_a", cmp_a, 32'd0);
    op_check("rst_done.next", 3'b000, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0);

    // flush in IDLE blocks acceptance
    in_valid = 1'b1; flush = 1'b1; in_op = 3'b000;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("fl_idle.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("fl_idle.out_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
